// File: rtl/cjb_alu_defs.sv
// -----------------------------------------------------------------------------
// cjb_alu_defs
// Shared definitions for the ALU arbiter and the 8-bit ALU.
//   - unit-select codes carried in Func_Sel[3:2]
//   - bit positions of the packed {C,N,V,Z} flag nibble
//   - arbiter FSM state encoding
//   - latched operation record used by the arbiter
// -----------------------------------------------------------------------------
package cjb_alu_defs;

   // Func_Sel[3:2] unit codes
   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_SR    = 2'b10;
   localparam logic [1:0] UNIT_CONST = 2'b11;

   // Bit positions inside a CNVZ nibble
   localparam int FLAG_C = 3;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 1;
   localparam int FLAG_Z = 0;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } arb_state_t;

   // One requester's operation as captured at grant time
   typedef struct packed {
      logic [3:0] func_sel;
      logic [7:0] x;
      logic [7:0] y;
      logic [1:0] k;
      logic       set_flags;
   } op_t;

   // Pack flags into the {C,N,V,Z} nibble; N and Z come from the result.
   function automatic logic [3:0] pack_cnvz(input logic c, input logic v,
                                            input logic [7:0] res);
      logic [3:0] f;
      f         = 4'b0000;
      f[FLAG_C] = c;
      f[FLAG_N] = res[7];
      f[FLAG_V] = v;
      f[FLAG_Z] = (res == 8'h00);
      return f;
   endfunction

endpackage

// File: rtl/cjb_8bit_alu_struc_v.sv
// -----------------------------------------------------------------------------
// cjb_8bit_alu_struc_v
// Purely combinational 8-bit ALU shared by the arbiter.
// Ports:
//   i_func_sel [3:0] : [3:2] unit, [1:0] operation within the unit
//   i_x, i_y   [7:0] : operands
//   i_k        [1:0] : constant field for the const unit
//   i_cin            : carry in (ADC and rotate-through-carry only)
//   o_result   [7:0] : result
//   o_cnvz     [3:0] : {C,N,V,Z}
// Operation table:
//   arith : 00 X+Y, 01 X+Y+cin, 10 X-Y (C = no borrow), 11 X+1
//   logic : 00 AND, 01 OR, 10 XOR, 11 NOT X              (C=V=0)
//   sr    : 00 SHL, 01 SHR, 10 ROL thru C, 11 ROR thru C (C = bit out, V=0)
//   const : 00 zext(K), 01 sext(K), 10 Y, 11 X           (C=V=0)
// -----------------------------------------------------------------------------
module cjb_8bit_alu_struc_v
   import cjb_alu_defs::*;
(
   input  logic [3:0] i_func_sel,
   input  logic [7:0] i_x,
   input  logic [7:0] i_y,
   input  logic [1:0] i_k,
   input  logic       i_cin,
   output logic [7:0] o_result,
   output logic [3:0] o_cnvz
);

   logic [7:0] w_b;
   logic       w_ci;
   logic [8:0] w_sum;
   logic [7:0] w_res;
   logic       w_c;
   logic       w_v;

   // Adder operand selection; subtraction is X + ~Y + 1.
   always_comb begin
      w_b  = i_y;
      w_ci = 1'b0;
      case (i_func_sel[1:0])
         2'b00:   begin w_b = i_y;   w_ci = 1'b0;  end
         2'b01:   begin w_b = i_y;   w_ci = i_cin; end
         2'b10:   begin w_b = ~i_y;  w_ci = 1'b1;  end
         default: begin w_b = 8'h01; w_ci = 1'b0;  end
      endcase
   end

   assign w_sum = {1'b0, i_x} + {1'b0, w_b} + {8'h00, w_ci};

   always_comb begin
      w_res = 8'h00;
      w_c   = 1'b0;
      w_v   = 1'b0;
      case (i_func_sel[3:2])
         UNIT_ARITH: begin
            w_res = w_sum[7:0];
            w_c   = w_sum[8];
            // Signed overflow: like-signed inputs giving an unlike-signed sum
            w_v   = (i_x[7] == w_b[7]) && (w_sum[7] != i_x[7]);
         end
         UNIT_LOGIC: begin
            case (i_func_sel[1:0])
               2'b00:   w_res = i_x & i_y;
               2'b01:   w_res = i_x | i_y;
               2'b10:   w_res = i_x ^ i_y;
               default: w_res = ~i_x;
            endcase
         end
         UNIT_SR: begin
            case (i_func_sel[1:0])
               2'b00:   begin w_res = {i_x[6:0], 1'b0};  w_c = i_x[7]; end
               2'b01:   begin w_res = {1'b0, i_x[7:1]};  w_c = i_x[0]; end
               2'b10:   begin w_res = {i_x[6:0], i_cin}; w_c = i_x[7]; end
               default: begin w_res = {i_cin, i_x[7:1]}; w_c = i_x[0]; end
            endcase
         end
         default: begin
            case (i_func_sel[1:0])
               2'b00:   w_res = {6'b000000, i_k};
               2'b01:   w_res = {{6{i_k[1]}}, i_k};
               2'b10:   w_res = i_y;
               default: w_res = i_x;
            endcase
         end
      endcase
   end

   assign o_result = w_res;
   assign o_cnvz   = pack_cnvz(w_c, w_v, w_res);

endmodule

// File: rtl/cjb_alu_arbiter_v.sv
// -----------------------------------------------------------------------------
// cjb_alu_arbiter_v
// Round-robin arbiter/sequencer giving two requesters access to one 8-bit ALU.
// A granted request has its operands latched, runs for one cycle on the ALU,
// and is answered by a one-cycle Ack with the registered result and flags.
// The block owns the CNVZ status register whose C bit is the ALU carry-in.
// Ports:
//   Clock, Reset          : clock, synchronous active-high reset
//   Req[1:0]              : per-requester request, held until its Ack
//   Func_Sel0/1, Operand_X0/Y0/X1/Y1, Const_K0/1, Set_Flags0/1 : operations
//   Ack[1:0]              : one-hot completion pulse
//   Result, Result_CNVZ   : registered result/flags, valid with Ack
//   Status_CNVZ           : architectural flag register
//   Busy                  : high whenever the FSM is not IDLE
// Timing: grant edge n, result captured at n+1, Ack high between n+2 and n+3.
// -----------------------------------------------------------------------------
module cjb_alu_arbiter_v
   import cjb_alu_defs::*;
#(
   parameter logic [3:0] RESET_FLAGS = 4'b0000
)(
   input  logic       Clock,
   input  logic       Reset,
   input  logic [1:0] Req,
   input  logic [3:0] Func_Sel0,
   input  logic [3:0] Func_Sel1,
   input  logic [7:0] Operand_X0,
   input  logic [7:0] Operand_Y0,
   input  logic [7:0] Operand_X1,
   input  logic [7:0] Operand_Y1,
   input  logic [1:0] Const_K0,
   input  logic [1:0] Const_K1,
   input  logic       Set_Flags0,
   input  logic       Set_Flags1,
   output logic [1:0] Ack,
   output logic [7:0] Result,
   output logic [3:0] Result_CNVZ,
   output logic [3:0] Status_CNVZ,
   output logic       Busy
);

   arb_state_t r_state;
   arb_state_t w_state_next;

   op_t        r_op;
   logic       r_owner;
   logic       r_last;
   logic [1:0] r_ack;
   logic [7:0] r_result;
   logic [3:0] r_result_cnvz;
   logic [3:0] r_status;

   // Per-requester views of the input buses
   logic [3:0] w_func [2];
   logic [7:0] w_x    [2];
   logic [7:0] w_y    [2];
   logic [1:0] w_k    [2];
   logic       w_sf   [2];
   op_t        w_req_op [2];

   logic       w_winner;
   logic       w_grant;
   logic       w_exec;
   logic       w_resp;
   logic [1:0] w_ack_next;
   logic       w_busy;

   logic [7:0] w_alu_result;
   logic [3:0] w_alu_cnvz;

   assign w_func[0] = Func_Sel0;   assign w_func[1] = Func_Sel1;
   assign w_x[0]    = Operand_X0;  assign w_x[1]    = Operand_X1;
   assign w_y[0]    = Operand_Y0;  assign w_y[1]    = Operand_Y1;
   assign w_k[0]    = Const_K0;    assign w_k[1]    = Const_K1;
   assign w_sf[0]   = Set_Flags0;  assign w_sf[1]   = Set_Flags1;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign w_req_op[gi] = '{func_sel:  w_func[gi],
                                 x:         w_x[gi],
                                 y:         w_y[gi],
                                 k:         w_k[gi],
                                 set_flags: w_sf[gi]};
      end
   endgenerate

   // Winner: a lone requester wins; on a tie the one not served last wins.
   always_comb begin
      case (Req)
         2'b01:   w_winner = 1'b0;
         2'b10:   w_winner = 1'b1;
         2'b11:   w_winner = ~r_last;
         default: w_winner = 1'b0;
      endcase
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge Clock) begin
      if (Reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (Req != 2'b00) w_state_next = ST_EXEC;
         ST_EXEC: w_state_next = ST_RESP;
         ST_RESP: w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   // ---------------- FSM: outputs / enables ----------------
   always_comb begin
      w_grant    = 1'b0;
      w_exec     = 1'b0;
      w_resp     = 1'b0;
      w_ack_next = 2'b00;
      w_busy     = 1'b1;
      case (r_state)
         ST_IDLE: begin
            w_busy  = 1'b0;
            w_grant = (Req != 2'b00);
         end
         ST_EXEC: w_exec = 1'b1;
         ST_RESP: begin
            w_resp     = 1'b1;
            w_ack_next = r_owner ? 2'b10 : 2'b01;
         end
         default: w_busy = 1'b0;
      endcase
   end

   // The ALU only ever sees the latched operation, so requester input
   // changes after the grant cannot disturb the in-flight result.
   cjb_8bit_alu_struc_v u_alu (
      .i_func_sel (r_op.func_sel),
      .i_x        (r_op.x),
      .i_y        (r_op.y),
      .i_k        (r_op.k),
      .i_cin      (r_status[FLAG_C]),
      .o_result   (w_alu_result),
      .o_cnvz     (w_alu_cnvz)
   );

   // Datapath registers. Ack is registered on the RESP->IDLE edge so it
   // lands one cycle after RESP and has no path from the inputs.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_op          <= '0;
         r_owner       <= 1'b0;
         r_last        <= 1'b1;
         r_ack         <= 2'b00;
         r_result      <= 8'h00;
         r_result_cnvz <= 4'h0;
         r_status      <= RESET_FLAGS;
      end else begin
         r_ack <= w_ack_next;
         if (w_grant) begin
            r_op    <= w_req_op[w_winner];
            r_owner <= w_winner;
         end
         if (w_exec) begin
            r_result      <= w_alu_result;
            r_result_cnvz <= w_alu_cnvz;
            if (r_op.set_flags) r_status <= w_alu_cnvz;
         end
         if (w_resp) r_last <= r_owner;
      end
   end

   assign Ack         = r_ack;
   assign Result      = r_result;
   assign Result_CNVZ = r_result_cnvz;
   assign Status_CNVZ = r_status;
   assign Busy        = w_busy;

endmodule

// File: tb/tb_cjb_alu_arbiter_v.sv
// -----------------------------------------------------------------------------
// tb_cjb_alu_arbiter_v
// Directed scoreboard bench: each issued operation pushes its expected
// completion (owner, result, flags, status, Ack cycle) into a queue; a
// separate monitor pops and compares whenever Ack is seen.
// -----------------------------------------------------------------------------
module tb_cjb_alu_arbiter_v;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] req;
   logic [3:0] fs0, fs1;
   logic [7:0] x0, y0, x1, y1;
   logic [1:0] k0, k1;
   logic       sf0, sf1;
   logic [1:0] ack;
   logic [7:0] result;
   logic [3:0] result_cnvz;
   logic [3:0] status_cnvz;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [1:0] ack;
      logic [7:0] res;
      logic [3:0] cnvz;
      logic [3:0] stat;
      int         cyc;
      string      nm;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;

   cjb_alu_arbiter_v #(.RESET_FLAGS(4'b0000)) dut (
      .Clock       (clk),
      .Reset       (rst),
      .Req         (req),
      .Func_Sel0   (fs0),
      .Func_Sel1   (fs1),
      .Operand_X0  (x0),
      .Operand_Y0  (y0),
      .Operand_X1  (x1),
      .Operand_Y1  (y1),
      .Const_K0    (k0),
      .Const_K1    (k1),
      .Set_Flags0  (sf0),
      .Set_Flags1  (sf1),
      .Ack         (ack),
      .Result      (result),
      .Result_CNVZ (result_cnvz),
      .Status_CNVZ (status_cnvz),
      .Busy        (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   // Monitor: compare every Ack against the oldest pending expectation.
   always @(negedge clk) begin
      if (ack !== 2'b00) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: Ack=%b with nothing pending (cycle %0d)", ack, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            $display("ack %s: Ack=%b Result=%h Result_CNVZ=%b Status=%b cycle=%0d",
                     mon_e.nm, ack, result, result_cnvz, status_cnvz, cyc);
            chk({mon_e.nm, ".ack"},    {30'd0, ack},         {30'd0, mon_e.ack});
            chk({mon_e.nm, ".result"}, {24'd0, result},      {24'd0, mon_e.res});
            chk({mon_e.nm, ".cnvz"},   {28'd0, result_cnvz}, {28'd0, mon_e.cnvz});
            chk({mon_e.nm, ".status"}, {28'd0, status_cnvz}, {28'd0, mon_e.stat});
            chk({mon_e.nm, ".cycle"},  cyc,                  mon_e.cyc);
         end
      end
   end

   task automatic push(input logic [1:0] a, input logic [7:0] r, input logic [3:0] c,
                       input logic [3:0] s, input int when, input string nm);
      exp_t e;
      e.ack = a; e.res = r; e.cnvz = c; e.stat = s; e.cyc = when; e.nm = nm;
      exp_q.push_back(e);
   endtask

   // Bounded wait for all pending Acks; an expired bound is a failed check.
   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s.drain: %0d Acks still pending, required 0", nm, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Single request; one cycle after the grant Req drops and all of that
   // requester's inputs are scrambled to show the latched copy is used.
   task automatic issue(input int idx, input logic [3:0] f, input logic [7:0] x,
                        input logic [7:0] y, input logic [1:0] k, input logic sf,
                        input logic [7:0] er, input logic [3:0] ec, input logic [3:0] es,
                        input string nm);
      @(negedge clk);
      if (idx == 0) begin
         fs0 = f; x0 = x; y0 = y; k0 = k; sf0 = sf; req = 2'b01;
      end else begin
         fs1 = f; x1 = x; y1 = y; k1 = k; sf1 = sf; req = 2'b10;
      end
      push((idx == 0) ? 2'b01 : 2'b10, er, ec, es, cyc + 3, nm);
      @(negedge clk);
      req = 2'b00;
      if (idx == 0) begin
         fs0 = f ^ 4'b0001; x0 = ~x; y0 = y + 8'h33; k0 = ~k; sf0 = ~sf;
      end else begin
         fs1 = f ^ 4'b0001; x1 = ~x; y1 = y + 8'h33; k1 = ~k; sf1 = ~sf;
      end
      wait_drain(nm);
   endtask

   initial begin
      int k_start;
      rst = 1'b1; req = 2'b00;
      fs0 = 4'h0; fs1 = 4'h0; x0 = 8'h00; y0 = 8'h00; x1 = 8'h00; y1 = 8'h00;
      k0 = 2'b00; k1 = 2'b00; sf0 = 1'b0; sf1 = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.ack",    {30'd0, ack},         32'h0);
      chk("reset.busy",   {31'd0, busy},        32'h0);
      chk("reset.result", {24'd0, result},      32'h00);
      chk("reset.rcnvz",  {28'd0, result_cnvz}, 32'h0);
      chk("reset.status", {28'd0, status_cnvz}, 32'h0);
      rst = 1'b0;

      //     req func     X      Y      K      sf    result cnvz     status
      issue(0, 4'b0000, 8'h7F, 8'h01, 2'b00, 1'b1, 8'h80, 4'b0110, 4'b0110, "add_7f_01");
      issue(0, 4'b0000, 8'hFF, 8'h01, 2'b00, 1'b1, 8'h00, 4'b1001, 4'b1001, "add_ff_01");
      issue(1, 4'b1010, 8'h80, 8'h00, 2'b00, 1'b1, 8'h01, 4'b1000, 4'b1000, "rol_cin1");
      issue(1, 4'b0110, 8'h5A, 8'h5A, 2'b00, 1'b0, 8'h00, 4'b0001, 4'b1000, "xor_noflags");
      issue(0, 4'b0001, 8'h10, 8'h20, 2'b00, 1'b0, 8'h31, 4'b0000, 4'b1000, "adc_cin1");
      issue(0, 4'b1100, 8'hAA, 8'h55, 2'b11, 1'b1, 8'h03, 4'b0000, 4'b0000, "const_k3");
      issue(1, 4'b0010, 8'h05, 8'h07, 2'b00, 1'b1, 8'hFE, 4'b0100, 4'b0100, "sub_5_7");

      // Reset during EXEC: no Ack, flags back to the reset value.
      @(negedge clk);
      fs0 = 4'b0000; x0 = 8'h11; y0 = 8'h22; sf0 = 1'b1; req = 2'b01;
      @(negedge clk);
      chk("rst_mid.busy_exec", {31'd0, busy}, 32'h1);
      rst = 1'b1; req = 2'b00;
      @(negedge clk);
      chk("rst_mid.busy",   {31'd0, busy},        32'h0);
      chk("rst_mid.ack",    {30'd0, ack},         32'h0);
      chk("rst_mid.status", {28'd0, status_cnvz}, 32'h0);
      chk("rst_mid.result", {24'd0, result},      32'h00);
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_mid.idle", {31'd0, busy}, 32'h0);

      // Contention with both requests held from reset: 01,10,01,10.
      rst = 1'b1;
      fs0 = 4'b0000; x0 = 8'h01; y0 = 8'h02; sf0 = 1'b0;
      fs1 = 4'b0100; x1 = 8'hF0; y1 = 8'h3C; sf1 = 1'b0;
      req = 2'b11;
      @(negedge clk);
      rst = 1'b0;
      k_start = cyc;
      push(2'b01, 8'h03, 4'b0000, 4'b0000, k_start + 3,  "rr0");
      push(2'b10, 8'h30, 4'b0000, 4'b0000, k_start + 6,  "rr1");
      push(2'b01, 8'h03, 4'b0000, 4'b0000, k_start + 9,  "rr2");
      push(2'b10, 8'h30, 4'b0000, 4'b0000, k_start + 12, "rr3");
      repeat (12) @(negedge clk);
      req = 2'b00;
      wait_drain("contention");
      repeat (4) @(negedge clk);
      chk("final.busy", {31'd0, busy}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/cjb_alu_arbiter_v.md
# cjb_alu_arbiter_v

Two-port arbiter and sequencer for the shared 8-bit ALU (`cjb_8bit_alu_struc_v`). It accepts operation requests from two requesters and grants them round-robin. Each granted operation has its operands latched, executes on the ALU, and is answered with a one-cycle acknowledge carrying the registered result. The block also owns the architectural CNVZ status register and feeds its C bit back as the ALU carry-in.

## Interface
- `RESET_FLAGS`, default 4'b0000: value loaded into `Status_CNVZ` on reset.
- `Clock` in 1: sole clock, rising edge.
- `Reset` in 1: synchronous, active-high.
- `Req` in 2: `Req[i]` is requester i's operation request. It is held until `Ack[i]`.
- `Func_Sel0`, `Func_Sel1` in 4: ALU function per requester. [3:2] is the unit (00 arith, 01 logic, 10 shift/rotate, 11 const).
- `Operand_X0`, `Operand_Y0`, `Operand_X1`, `Operand_Y1` in 8: operands per requester.
- `Const_K0`, `Const_K1` in 2: constant field per requester.
- `Set_Flags0`, `Set_Flags1` in 1: when 1, the operation updates `Status_CNVZ`.
- `Ack` out 2: one-hot, one-cycle pulse to the requester that owns the completed operation.
- `Result` out 8: registered ALU result. Valid while any `Ack` bit is 1.
- `Result_CNVZ` out 4: registered flags of the completed operation ({C,N,V,Z}). Valid with `Ack`.
- `Status_CNVZ` out 4: architectural flag register.
- `Busy` out 1: 1 in any state other than IDLE.

## Operation
- FSM has three states: IDLE, EXEC, RESP.
- **IDLE**
  - With `Req==0`, stay in IDLE.
  - Otherwise choose a winner:
    - If only one bit is set, that requester wins.
    - If both are set, the requester other than `Last` wins.
  - Latch the winner's Func_Sel, X, Y, K and Set_Flags into operation registers.
  - `Owner <= winner`, go to EXEC.
- **EXEC**
  - The ALU is driven only from the operation registers; `cin = Status_CNVZ[3]`.
  - Capture `Result <= ALU_Result` and `Result_CNVZ <= ALU_CNVZ`.
  - If the latched Set_Flags is 1, `Status_CNVZ <= ALU_CNVZ`.
  - Go to RESP.
- **RESP**
  - `Ack[Owner]=1`; `Last <= Owner`; go to IDLE.
- Requester inputs are sampled only on the IDLE→EXEC edge. Later changes to operands, or dropping `Req`, do not affect the in-flight operation. Its Ack still pulses.
- A requester that keeps `Req` high after its Ack makes a new request. Under contention, round-robin gives the next grant to the other requester.
- `Result`, `Result_CNVZ` and `Status_CNVZ` hold their values between operations.
- Reset values:
  - state IDLE.
  - `Ack=0`, `Busy=0`.
  - `Result=8'h00`, `Result_CNVZ=4'h0`.
  - `Status_CNVZ=RESET_FLAGS`.
  - `Last=1`, so requester 0 wins the first tie.
  - `Owner=0`.
- Reset asserted in EXEC or RESP: return to IDLE. No Ack is issued and `Status_CNVZ` is not updated on that edge.

## Timing
- Req sampled high at edge n (IDLE) → EXEC in cycle n..n+1 → `Ack` high for exactly the cycle between edges n+2 and n+3.
- Latency is 2 cycles from the grant edge to Ack. Throughput is 1 operation per 3 cycles.
- `Busy` rises the cycle after the grant edge and falls after RESP.
- `Ack`, `Busy` and `Result` derive from registers only, with no combinational path from inputs.
- An operation's flag write takes effect at the EXEC edge, so a back-to-back operation (granted at the edge after RESP) sees the updated C as cin.

## Structure
- Shared package/header `cjb_alu_defs`:
  - unit-select codes ARITH/LOGIC/SR/CONST.
  - CNVZ bit indices (C=3, N=2, V=1, Z=0).
  - FSM state encodings.
- One sub-module: a single instance of `cjb_8bit_alu_struc_v`. The arbiter logic and FSM live in this module.

## Test plan
- Single request, flags enabled:
  - `Req=2'b01`, Func_Sel0=4'b0000 (add), X=8'h7F, Y=8'h01, Set_Flags0=1.
  - Expect: Ack=2'b01 two cycles after the grant edge, Result=8'h80, Result_CNVZ=4'b0110, Status_CNVZ=4'b0110.
- Carry chain:
  - First op: add 8'hFF+8'h01 with flags. Expect Result=8'h00, Status_CNVZ=4'b1001.
  - Then a rotate-through-carry op from requester 1. Expect cin=1 at the ALU.
- Contention:
  - `Req=2'b11` held continuously from reset.
  - Expect Ack order 01,10,01,10, each 3 cycles apart.
- Set_Flags=0:
  - Op with Set_Flags=0 yielding Z=1.
  - Expect Result_CNVZ[0]=1 while Status_CNVZ is unchanged.
- Mid-op changes:
  - Drop `Req` and change the operands one cycle after the grant.
  - Expect Ack still issued with a Result from the originally latched operands.
- Reset mid-op:
  - Assert Reset during EXEC.
  - Expect no Ack, Busy=0 the next cycle, Status_CNVZ=RESET_FLAGS, Result=8'h00.
